simon_game_ctrl: RTL and testbench
==================================

Name: simon_game_ctrl

Overview:
Top-level round sequencer for the colour memory game.
- Plays the golden sequence on the LED for the current round.
- Collects the player's 2-bit colour presses into a 32-bit sequence register.
- Launches the sequence-check block and interprets its one-cycle success pulse.
- Owns the round counter and the WIN/LOSE terminal states. Sits between the button/LED I/O and the check block.

Parameters:
DISP_ON_CYC, 1000, clocks each colour is shown with led_on=1
DISP_OFF_CYC, 250, clocks of blank gap after each colour
TIMEOUT_CYC, 100000, clocks without a press in INPUT before a loss
MAX_ROUND, 15, last round index; success in this round means a win

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; begins a game from IDLE/WIN/LOSE
btn_valid  in  1  one-cycle pulse, player pressed a colour
btn_colour  in  2  colour pressed, valid with btn_valid
seq_mem  in  32  golden sequence; colour i at bits [2i+1:2i]
complete_check  in  1  success pulse from check block, one cycle after chk_en
game_complete  in  1  final-round success flag from check block
seq_in  out  32  player sequence to check block, same packing
chk_en  out  1  one-cycle launch of check block
chk_rst  out  1  one-cycle synchronous reset of check block
round_ctr  out  4  current round, 0..MAX_ROUND
led_on  out  1  display LED enable
led_colour  out  2  colour being displayed
state_o  out  3  current FSM state encoding

Behaviour:
Reset (rst_n=0, asynchronous):
- state=IDLE; round_ctr=0; seq_in=0; all pulses 0; led_on=0; led_colour=0; internal idx, timers and phase flag cleared.

State encoding: IDLE=0, DISPLAY=1, INPUT=2, CHECK_REQ=3, CHECK_WAIT=4, WIN=5, LOSE=6. All outputs are registered.

IDLE:
- start=1 -> DISPLAY; round_ctr=0, seq_in=0, idx=0, chk_rst=1 for one cycle.

DISPLAY:
- For idx=0..round_ctr: led_on=1 and led_colour=seq_mem[2*idx+:2] for DISP_ON_CYC clocks, then led_on=0 for DISP_OFF_CYC clocks.
- After the gap of idx==round_ctr -> INPUT with idx=0 and timeout counter=0.
- btn_valid and start are ignored.

INPUT:
- btn_valid=1 -> seq_in[2*idx+:2]<=btn_colour, idx<=idx+1, timeout counter cleared.
- If the stored press has idx==round_ctr -> CHECK_REQ in the next cycle.
- Timeout counter reaching TIMEOUT_CYC-1 with no press -> LOSE.
- A press in the same cycle as timeout expiry wins: the press is accepted and the timeout is not taken.
- start is ignored.

CHECK_REQ:
- chk_en=1 for exactly one cycle -> CHECK_WAIT.

CHECK_WAIT (one cycle), sampling complete_check:
- complete_check=1 and round_ctr==MAX_ROUND (game_complete=1 in this case) -> WIN.
- complete_check=1 otherwise -> round_ctr+1, idx=0 -> DISPLAY.
- complete_check=0 -> LOSE.

WIN / LOSE:
- led_on=0; hold the state until start.
- start -> same action as from IDLE, i.e. round_ctr=0 and the game restarts.

Width and boundary rules:
- idx is 4 bits; round_ctr never exceeds MAX_ROUND.
- Bits of seq_in above the current round are left as written; the check block masks them.
- chk_en and chk_rst are never high in the same cycle.
- rst_n deassertion mid-game returns to IDLE; no partial state survives.

Decomposition:
- Shared package simon_pkg: state enum/encodings, COLOUR_W=2, SEQ_W=32, MAX_ROUND.
- Sub-module simon_led_player: DISPLAY-phase on/off timer plus colour-index stepping, with start/done handshake. The FSM, INPUT capture and check handshake stay in the top module.

Test Plan:
All scenarios use DISP_ON_CYC=4, DISP_OFF_CYC=2, TIMEOUT_CYC=20.
1. Reset, then start with seq_mem=32'h0000_00E4 -> chk_rst pulses once; led_colour=0 with led_on=1 for 4 clocks, then led_on=0 for 2 clocks; state_o=2.
2. Round 0, press colour 0; model the check block returning complete_check -> chk_en high one cycle after the press; round_ctr becomes 1; DISPLAY shows colours 0 then 1.
3. Round 1, press 0 then 2, complete_check=0 in CHECK_WAIT -> state_o=6; seq_in[3:0]=4'b1000; led_on stays 0; later presses are ignored.
4. In INPUT, no presses for 20 clocks -> LOSE after exactly 20 clocks; a press on clock 19 instead is accepted and the timer restarts.
5. Preload round_ctr=15 via successive successes, then a correct 16 presses with complete_check=1 and game_complete=1 -> state_o=5; start -> round_ctr=0, DISPLAY.
6. Assert rst_n=0 asynchronously in CHECK_WAIT -> outputs clear immediately, without waiting for a clock edge; state_o=0.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared encodings and widths for the colour memory game controller.
package simon_pkg;
   localparam int COLOUR_W = 2;
   localparam int SEQ_W    = 32;
   localparam int IDX_W    = 4;

   localparam logic [IDX_W-1:0] MAX_ROUND = 4'd15;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_DISPLAY    = 3'd1;
   localparam logic [2:0] ST_INPUT      = 3'd2;
   localparam logic [2:0] ST_CHECK_REQ  = 3'd3;
   localparam logic [2:0] ST_CHECK_WAIT = 3'd4;
   localparam logic [2:0] ST_WIN        = 3'd5;
   localparam logic [2:0] ST_LOSE       = 3'd6;

   typedef logic [COLOUR_W-1:0] colour_t;

   function automatic colour_t seq_colour(input logic [SEQ_W-1:0] seq, input logic [IDX_W-1:0] idx);
      return seq[{idx, 1'b0} +: COLOUR_W];
   endfunction
endpackage

// File: rtl/simon_game_ctrl_if.sv
// Button/LED and check-block signals of the game controller; slave is the controller side.
interface simon_game_ctrl_if;
   import simon_pkg::*;

   logic             start;
   logic             btn_valid;
   colour_t          btn_colour;
   logic [SEQ_W-1:0] seq_mem;
   logic             complete_check;
   logic             game_complete;
   logic [SEQ_W-1:0] seq_in;
   logic             chk_en;
   logic             chk_rst;
   logic [IDX_W-1:0] round_ctr;
   logic             led_on;
   colour_t          led_colour;
   logic [2:0]       state_o;

   modport master (
      output start, btn_valid, btn_colour, seq_mem, complete_check, game_complete,
      input  seq_in, chk_en, chk_rst, round_ctr, led_on, led_colour, state_o
   );

   modport slave (
      input  start, btn_valid, btn_colour, seq_mem, complete_check, game_complete,
      output seq_in, chk_en, chk_rst, round_ctr, led_on, led_colour, state_o
   );
endinterface

// File: rtl/simon_led_player.sv
// Shows colours 0..last of the golden sequence, ON_CYC clocks lit then OFF_CYC dark each.
// LED lights in the cycle after start; done is asserted combinationally in the last dark cycle.
module simon_led_player
   import simon_pkg::*;
#(
   parameter int ON_CYC  = 1000,
   parameter int OFF_CYC = 250
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [IDX_W-1:0] last,
   input  logic [SEQ_W-1:0] seq_mem,
   output logic             led_on,
   output colour_t          led_colour,
   output logic             done
);
   localparam int T_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
   localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   logic             busy;
   logic             off_ph;
   logic [TW-1:0]    tmr;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] last_q;
   logic             on_end;
   logic             off_end;

   assign on_end  = (tmr == TW'(ON_CYC - 1));
   assign off_end = (tmr == TW'(OFF_CYC - 1));
   assign done    = busy && off_ph && off_end && (idx == last_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy       <= 1'b0;
         off_ph     <= 1'b0;
         tmr        <= '0;
         idx        <= '0;
         last_q     <= '0;
         led_on     <= 1'b0;
         led_colour <= '0;
      end else if (start) begin
         busy       <= 1'b1;
         off_ph     <= 1'b0;
         tmr        <= '0;
         idx        <= '0;
         last_q     <= last;
         led_on     <= 1'b1;
         led_colour <= seq_colour(seq_mem, '0);
      end else if (busy) begin
         if (!off_ph) begin
            if (on_end) begin
               off_ph <= 1'b1;
               tmr    <= '0;
               led_on <= 1'b0;
            end else begin
               tmr <= tmr + 1'b1;
            end
         end else if (off_end) begin
            if (idx == last_q) begin
               busy <= 1'b0;
            end else begin
               idx        <= idx + 1'b1;
               off_ph     <= 1'b0;
               tmr        <= '0;
               led_on     <= 1'b1;
               led_colour <= seq_colour(seq_mem, idx + 1'b1);
            end
         end else begin
            tmr <= tmr + 1'b1;
         end
      end
   end
endmodule

// File: rtl/simon_game_ctrl.sv
// Round sequencer: plays the golden sequence, captures presses, launches the check block.
// All outputs registered; chk_en follows the final press by one cycle, result sampled one cycle later.
module simon_game_ctrl
   import simon_pkg::*;
#(
   parameter int DISP_ON_CYC  = 1000,
   parameter int DISP_OFF_CYC = 250,
   parameter int TIMEOUT_CYC  = 100000
) (
   input logic               clk,
   input logic               rst_n,
   simon_game_ctrl_if.slave  io
);
   localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [2:0]       state;
   logic [IDX_W-1:0] rnd;
   logic [IDX_W-1:0] idx;
   logic [TMR_W-1:0] tmr;
   logic [SEQ_W-1:0] seq;
   logic             chk_en;
   logic             chk_rst;
   logic             go_start;
   logic             last_round;
   logic             chk_pass;
   logic             play_start;
   logic             play_done;
   logic [IDX_W-1:0] play_last;

   assign go_start   = io.start && (state == ST_IDLE || state == ST_WIN || state == ST_LOSE);
   // game_complete only ever accompanies success in the final round, so either marks a win
   assign last_round = (rnd == MAX_ROUND) || io.game_complete;
   assign chk_pass   = (state == ST_CHECK_WAIT) && io.complete_check && !last_round;
   assign play_start = go_start || chk_pass;
   assign play_last  = go_start ? '0 : rnd + 1'b1;

   simon_led_player #(
      .ON_CYC  (DISP_ON_CYC),
      .OFF_CYC (DISP_OFF_CYC)
   ) u_player (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (play_start),
      .last       (play_last),
      .seq_mem    (io.seq_mem),
      .led_on     (io.led_on),
      .led_colour (io.led_colour),
      .done       (play_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         rnd     <= '0;
         idx     <= '0;
         tmr     <= '0;
         seq     <= '0;
         chk_en  <= 1'b0;
         chk_rst <= 1'b0;
      end else begin
         chk_en  <= 1'b0;
         chk_rst <= 1'b0;
         case (state)
            ST_IDLE, ST_WIN, ST_LOSE: begin
               if (io.start) begin
                  state   <= ST_DISPLAY;
                  rnd     <= '0;
                  idx     <= '0;
                  seq     <= '0;
                  chk_rst <= 1'b1;
               end
            end
            ST_DISPLAY: begin
               if (play_done) begin
                  state <= ST_INPUT;
                  idx   <= '0;
                  tmr   <= '0;
               end
            end
            ST_INPUT: begin
               // a press in the expiry cycle takes priority over the timeout
               if (io.btn_valid) begin
                  seq[{idx, 1'b0} +: COLOUR_W] <= io.btn_colour;
                  idx <= idx + 1'b1;
                  tmr <= '0;
                  if (idx == rnd) begin
                     state  <= ST_CHECK_REQ;
                     chk_en <= 1'b1;
                  end
               end else if (tmr == TMR_W'(TIMEOUT_CYC - 1)) begin
                  state <= ST_LOSE;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            ST_CHECK_REQ: state <= ST_CHECK_WAIT;
            ST_CHECK_WAIT: begin
               if (!io.complete_check) begin
                  state <= ST_LOSE;
               end else if (last_round) begin
                  state <= ST_WIN;
               end else begin
                  rnd   <= rnd + 1'b1;
                  idx   <= '0;
                  state <= ST_DISPLAY;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign io.seq_in    = seq;
   assign io.chk_en    = chk_en;
   assign io.chk_rst   = chk_rst;
   assign io.round_ctr = rnd;
   assign io.state_o   = state;
endmodule

// File: tb/tb_simon_game_ctrl.sv
// Bench for simon_game_ctrl: directed rounds plus a randomized full game against a rule-level model.
`timescale 1ns/1ps
module tb_simon_game_ctrl;
   import simon_pkg::*;

   localparam int ON        = 4;
   localparam int OFF       = 2;
   localparam int TO        = 20;
   localparam int LAST_RND  = 15;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   simon_game_ctrl_if io();

   simon_game_ctrl #(
      .DISP_ON_CYC  (ON),
      .DISP_OFF_CYC (OFF),
      .TIMEOUT_CYC  (TO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io)
   );

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [31:0] mem;
   logic [31:0] exp_seq;
   int          exp_round;
   int          exp_idx;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [1:0] gold(input int i);
      return 2'((mem >> (2 * i)) & 32'h3);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_game();
      io.start = 1'b1;
      tick();
      io.start = 1'b0;
      exp_round = 0;
      exp_seq   = 32'h0;
      chk("start_state", io.state_o, 1);
      chk("start_chk_rst", io.chk_rst, 1);
      chk("start_chk_en", io.chk_en, 0);
      chk("start_round", io.round_ctr, 0);
      chk("start_seq_in", io.seq_in, 0);
   endtask

   // called in the first DISPLAY cycle; noise on btn_valid/start must be ignored
   task automatic show_round(input bit fresh);
      for (int i = 0; i <= exp_round; i++) begin
         for (int c = 0; c < ON + OFF; c++) begin
            chk("disp_state", io.state_o, 1);
            chk("disp_led_on", io.led_on, (c < ON) ? 1 : 0);
            if (c < ON) chk("disp_colour", io.led_colour, gold(i));
            chk("disp_chk_rst", io.chk_rst, (fresh && i == 0 && c == 0) ? 1 : 0);
            chk("disp_chk_en", io.chk_en, 0);
            io.btn_valid  = 1'($urandom_range(0, 1));
            io.btn_colour = 2'($urandom_range(0, 3));
            io.start      = ($urandom_range(0, 7) == 0);
            tick();
         end
      end
      io.btn_valid = 1'b0;
      io.start     = 1'b0;
      chk("disp_to_input", io.state_o, 2);
      chk("disp_seq_kept", io.seq_in, exp_seq);
      exp_idx = 0;
   endtask

   task automatic press(input logic [1:0] col, input int d);
      for (int j = 0; j < d; j++) begin
         chk("input_wait_state", io.state_o, 2);
         chk("input_no_chk_en", io.chk_en, 0);
         tick();
      end
      io.btn_valid  = 1'b1;
      io.btn_colour = col;
      tick();
      io.btn_valid = 1'b0;
      exp_seq[2 * exp_idx +: 2] = col;
      if (exp_idx == exp_round) begin
         chk("req_state", io.state_o, 3);
         chk("req_chk_en", io.chk_en, 1);
         chk("req_chk_rst", io.chk_rst, 0);
         chk("req_seq_in", io.seq_in, exp_seq);
      end else begin
         chk("press_state", io.state_o, 2);
         chk("press_seq_in", io.seq_in, exp_seq);
         exp_idx++;
      end
   endtask

   task automatic resolve(input bit pass);
      tick();
      chk("wait_state", io.state_o, 4);
      chk("wait_chk_en", io.chk_en, 0);
      io.complete_check = pass;
      io.game_complete  = pass && (exp_round == LAST_RND);
      tick();
      io.complete_check = 1'b0;
      io.game_complete  = 1'b0;
      if (!pass) begin
         chk("lose_state", io.state_o, 6);
         chk("lose_led_on", io.led_on, 0);
      end else if (exp_round == LAST_RND) begin
         chk("win_state", io.state_o, 5);
         chk("win_round", io.round_ctr, LAST_RND);
         chk("win_led_on", io.led_on, 0);
      end else begin
         exp_round++;
         chk("next_state", io.state_o, 1);
         chk("next_round", io.round_ctr, exp_round);
         chk("next_led_on", io.led_on, 1);
         chk("next_colour", io.led_colour, gold(0));
      end
   endtask

   task automatic expire();
      for (int j = 1; j <= TO; j++) begin
         tick();
         chk("timeout_state", io.state_o, (j < TO) ? 2 : 6);
      end
   endtask

   task automatic ignored_after_end(input int st);
      for (int j = 0; j < 3; j++) begin
         io.btn_valid  = 1'b1;
         io.btn_colour = 2'($urandom_range(0, 3));
         tick();
         chk("end_state_hold", io.state_o, st);
         chk("end_seq_hold", io.seq_in, exp_seq);
         chk("end_led_off", io.led_on, 0);
      end
      io.btn_valid = 1'b0;
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_state"}, io.state_o, 0);
      chk({tag, "_round"}, io.round_ctr, 0);
      chk({tag, "_seq_in"}, io.seq_in, 0);
      chk({tag, "_chk_en"}, io.chk_en, 0);
      chk({tag, "_chk_rst"}, io.chk_rst, 0);
      chk({tag, "_led_on"}, io.led_on, 0);
      chk({tag, "_led_colour"}, io.led_colour, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      io.start          = 1'b0;
      io.btn_valid      = 1'b0;
      io.btn_colour     = 2'd0;
      io.complete_check = 1'b0;
      io.game_complete  = 1'b0;
      mem               = 32'h0000_00E4;
      io.seq_mem        = mem;
      exp_seq           = 32'h0;
      exp_round         = 0;
      exp_idx           = 0;

      #12;
      check_cleared("reset");
      @(negedge clk) rst_n = 1'b1;
      tick();
      chk("idle_state", io.state_o, 0);

      // directed: round 0 success, round 1 wrong second colour
      start_game();
      show_round(1'b1);
      press(2'd0, 3);
      resolve(1'b1);
      show_round(1'b0);
      press(2'd0, 1);
      press(2'd2, 0);
      resolve(1'b0);
      chk("lose_seq_low", {28'h0, io.seq_in[3:0]}, 32'h8);
      ignored_after_end(6);

      // timeout with no presses
      start_game();
      show_round(1'b1);
      expire();

      // presses in the expiry cycle win and restart the timer
      start_game();
      show_round(1'b1);
      press(gold(0), TO - 1);
      resolve(1'b1);
      show_round(1'b0);
      press(gold(0), TO - 1);
      press(gold(1), TO - 1);
      resolve(1'b1);
      show_round(1'b0);
      press(gold(0), 5);
      expire();

      // randomized full game to a win
      mem        = $urandom;
      io.seq_mem = mem;
      start_game();
      show_round(1'b1);
      for (int r = 0; r <= LAST_RND; r++) begin
         for (int k = 0; k <= r; k++) press(gold(k), $urandom_range(0, TO - 1));
         resolve(1'b1);
         if (r < LAST_RND) show_round(1'b0);
      end
      ignored_after_end(5);

      // restart from WIN, then asynchronous reset in CHECK_WAIT
      start_game();
      show_round(1'b1);
      press(gold(0), 2);
      tick();
      chk("pre_reset_state", io.state_o, 4);
      #2 rst_n = 1'b0;
      #1;
      check_cleared("async_reset");
      @(negedge clk) rst_n = 1'b1;
      tick();
      chk("post_reset_state", io.state_o, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
